// File: rtl/nand_fault_injector.sv
// rtl/nand_fault_injector.sv - seeded, per-page budgeted bit-flip injector for the NAND read byte stream
//
// Sits between DIO byte capture and the ECC/decoder path. For every accepted
// byte a Galois LFSR decides whether one bit is flipped, bounded by a per-page
// fault budget latched at page_start. One-deep registered output stage, so
// latency is one cycle and the output holds stable under backpressure.
//
// Ports:
//   HCLK, HRESET                    clock, synchronous active-high reset
//   cfg_en                          1 = inject, 0 = pass-through
//   cfg_prob[8:0]                   fault when {1'b0,lfsr[7:0]} < cfg_prob (256 = always)
//   cfg_num_faults                  per-page budget, clamped to MAX_FAULTS
//   cfg_seed_load, cfg_seed         reseed LFSR while idle (0 selects SEED)
//   page_start                      one-cycle pulse: begin (or restart) a page
//   in_valid/in_data/in_ready       input byte stream
//   out_valid/out_data/out_ready    output byte stream
//   out_last                        marks byte PAGE_BYTES-1
//   fault_cnt                       faults injected in the current page
//   busy, page_done                 state != IDLE, one-cycle end-of-page pulse
//
// Optional: define NAND_FAULT_LOG_EN to add a LOG_DEPTH-entry fault log FIFO
// with ports log_valid, log_data[14:0] = {byte_index[11:0], bit[2:0]},
// log_pop and log_ovf (sticky until page_start).
`timescale 1ns/1ps
module nand_fault_injector #(
  parameter int                DATA_W     = 8,
  parameter int                PAGE_BYTES = 2112,
  parameter int                MAX_FAULTS = 80,
  parameter int                LFSR_W     = 32,
  parameter logic [LFSR_W-1:0] SEED       = 32'hACE1_2020
`ifdef NAND_FAULT_LOG_EN
  ,
  parameter int                LOG_DEPTH  = 16
`endif
) (
  input  logic                            HCLK,
  input  logic                            HRESET,
  input  logic                            cfg_en,
  input  logic [8:0]                      cfg_prob,
  input  logic [$clog2(MAX_FAULTS+1)-1:0] cfg_num_faults,
  input  logic                            cfg_seed_load,
  input  logic [LFSR_W-1:0]               cfg_seed,
  input  logic                            page_start,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [DATA_W-1:0]               out_data,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [$clog2(MAX_FAULTS+1)-1:0] fault_cnt,
  output logic                            busy,
  output logic                            page_done
`ifdef NAND_FAULT_LOG_EN
  ,
  output logic                            log_valid,
  output logic [14:0]                     log_data,
  input  logic                            log_pop,
  output logic                            log_ovf
`endif
);

  localparam int NF_W  = $clog2(MAX_FAULTS + 1);
  localparam int IDX_W = $clog2(PAGE_BYTES + 1);

  localparam logic [NF_W-1:0]   MAX_FAULTS_C = NF_W'(MAX_FAULTS);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(PAGE_BYTES - 1);
  localparam logic [IDX_W-1:0]  PAGE_END     = IDX_W'(PAGE_BYTES);
  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_POLY    = LFSR_W'(32'h8020_0003);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]        state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_step;
  logic [LFSR_W-1:0] seed_eff;
  logic [IDX_W-1:0]  byte_idx;   // next byte index to accept; PAGE_END once the page is in
  logic [NF_W-1:0]   budget;

  logic              restart;
  logic              accept;
  logic              out_fire;
  logic [NF_W-1:0]   cfg_budget;
  logic [IDX_W-1:0]  cur_idx;
  logic [NF_W-1:0]   cur_cnt;
  logic [NF_W-1:0]   cur_budget;
  logic              prob_hit;
  logic              inject;
  logic [2:0]        bit_pos;
  logic [DATA_W-1:0] flip_mask;

  // page_start is honoured in IDLE and STREAM; DONE ignores it.
  assign restart   = page_start && (state != ST_DONE);
  assign in_ready  = (state == ST_STREAM) && (byte_idx != PAGE_END) &&
                     (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != ST_IDLE);
  assign page_done = (state == ST_DONE);

  assign cfg_budget = (cfg_num_faults > MAX_FAULTS_C) ? MAX_FAULTS_C : cfg_num_faults;

  // A byte accepted in the same cycle as a restart is byte 0 of the new page.
  assign cur_idx    = restart ? '0 : byte_idx;
  assign cur_cnt    = restart ? '0 : fault_cnt;
  assign cur_budget = restart ? cfg_budget : budget;

  assign prob_hit  = ({1'b0, lfsr[7:0]} < cfg_prob);
  assign inject    = accept && cfg_en && (cur_cnt < cur_budget) && prob_hit;
  assign bit_pos   = 3'(32'(lfsr[10:8]) % DATA_W);
  assign flip_mask = DATA_W'(1) << bit_pos;

  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
  assign seed_eff  = (cfg_seed == '0) ? SEED : cfg_seed;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (page_start) state <= ST_STREAM;
        // a restart wins over a last-byte handshake in the same cycle
        ST_STREAM: if (!page_start && out_fire && out_last) state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      lfsr      <= SEED;
      byte_idx  <= '0;
      fault_cnt <= '0;
      budget    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      // Reseed only while idle; otherwise the LFSR moves exactly once per accept.
      if ((state == ST_IDLE) && cfg_seed_load) begin
        lfsr <= seed_eff;
      end else if (accept) begin
        lfsr <= lfsr_step;
      end

      if (restart) begin
        budget    <= cfg_budget;
        byte_idx  <= '0;
        fault_cnt <= '0;
      end

      if (accept) begin
        byte_idx <= cur_idx + IDX_W'(1);
        if (inject) fault_cnt <= cur_cnt + NF_W'(1);
      end

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ (inject ? flip_mask : '0);
        out_last  <= (cur_idx == LAST_IDX);
      end else begin
        if (out_fire) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
        // A byte still held across a restart belongs to the aborted page.
        if (restart) out_last <= 1'b0;
      end
    end
  end

`ifdef NAND_FAULT_LOG_EN
  localparam int LP_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  logic [14:0]   log_mem [LOG_DEPTH];
  logic [LP_W-1:0] log_wr;
  logic [LP_W-1:0] log_rd;
  logic [LP_W:0]   log_count;
  logic            log_full;
  logic            log_take;
  logic            log_push;

  function automatic logic [LP_W-1:0] ptr_next(input logic [LP_W-1:0] p);
    return (p == LP_W'(LOG_DEPTH - 1)) ? '0 : p + LP_W'(1);
  endfunction

  assign log_full  = (log_count == (LP_W+1)'(LOG_DEPTH));
  assign log_take  = log_pop && log_valid;
  // A pop in the same cycle frees the slot the push needs.
  assign log_push  = inject && (!log_full || log_take);
  assign log_valid = (log_count != '0);
  assign log_data  = log_mem[log_rd];

  always_ff @(posedge HCLK) begin
    if (log_push) log_mem[log_wr] <= {12'(cur_idx), bit_pos};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      log_wr    <= '0;
      log_rd    <= '0;
      log_count <= '0;
      log_ovf   <= 1'b0;
    end else begin
      if (log_push) log_wr <= ptr_next(log_wr);
      if (log_take) log_rd <= ptr_next(log_rd);
      case ({log_push, log_take})
        2'b10:   log_count <= log_count + (LP_W+1)'(1);
        2'b01:   log_count <= log_count - (LP_W+1)'(1);
        default: log_count <= log_count;
      endcase
      // dropped entries win over the clear so a drop on the restart cycle is kept
      if (inject && !log_push) log_ovf <= 1'b1;
      else if (restart)        log_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_nand_fault_injector.sv
// tb/tb_nand_fault_injector.sv - directed self-checking bench for nand_fault_injector
`timescale 1ns/1ps
module tb_nand_fault_injector;

  localparam int          PAGE   = 2112;
  localparam logic [31:0] SEED_C = 32'hACE1_2020;
  localparam logic [31:0] POLY_C = 32'h8020_0003;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cfg_en = 1'b0;
  logic [8:0]  cfg_prob = '0;
  logic [6:0]  cfg_num_faults = '0;
  logic        cfg_seed_load = 1'b0;
  logic [31:0] cfg_seed = '0;
  logic        page_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [6:0]  fault_cnt;
  logic        busy;
  logic        page_done;

  always #5 HCLK = ~HCLK;

  nand_fault_injector dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_en(cfg_en), .cfg_prob(cfg_prob),
    .cfg_num_faults(cfg_num_faults), .cfg_seed_load(cfg_seed_load), .cfg_seed(cfg_seed),
    .page_start(page_start), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
    .fault_cnt(fault_cnt), .busy(busy), .page_done(page_done)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  stim     [PAGE];
  logic [7:0]  exp_data [PAGE];
  logic [7:0]  cap_data [PAGE];
  logic [7:0]  cap_prev [PAGE];
  int          exp_cnt  [PAGE];
  logic [31:0] traj     [PAGE+1];
  int          exp_total;
  logic [31:0] m_lfsr;
  int          ready_pct = 100;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ POLY_C) : (l >> 1);
  endfunction

  // Expected page: walk the random sequence once per byte, flipping bit
  // l[10:8] while the clamped budget lasts and the probability test passes.
  task automatic model_build(input int prob, input int budget, input bit en);
    logic [31:0] l;
    int cnt;
    int eb;
    l   = m_lfsr;
    cnt = 0;
    eb  = (budget > 80) ? 80 : budget;
    for (int k = 0; k < PAGE; k++) begin
      traj[k] = l;
      if (en && cnt < eb && int'(l[7:0]) < prob) begin
        exp_data[k] = stim[k] ^ (8'd1 << l[10:8]);
        cnt++;
      end else begin
        exp_data[k] = stim[k];
      end
      exp_cnt[k] = cnt;
      l = lfsr_next(l);
    end
    traj[PAGE] = l;
    exp_total  = cnt;
  endtask

  // Output sink: random out_ready at the requested duty.
  initial begin
    forever begin
      @(posedge HCLK);
      #1;
      out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Per-cycle compare against the model.
  int         out_k = 0;
  logic       prev_stall = 1'b0;
  logic       prev_last_hs = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_lastv = 1'b0;

  always @(negedge HCLK) begin
    if (!mon_en) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (page_start) out_k = 0;
      check("page_done_timing", page_done, prev_last_hs);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_lastv);
      end
      prev_last_hs = 1'b0;
      if (out_valid && out_ready) begin
        if (out_k >= PAGE) begin
          check("extra_byte_index", out_k, PAGE - 1);
        end else begin
          check("out_data", out_data, exp_data[out_k]);
          check("out_last", out_last, (out_k == PAGE - 1));
          check("fault_cnt_run", fault_cnt, exp_cnt[out_k]);
          cap_data[out_k] = out_data;
          prev_last_hs = (out_k == PAGE - 1);
          out_k++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_lastv = out_last;
    end
  end

  task automatic gen_stim(input bit rnd);
    for (int k = 0; k < PAGE; k++) stim[k] = rnd ? 8'($urandom) : k[7:0];
  endtask

  task automatic load_seed(input logic [31:0] s);
    cfg_seed = s;
    cfg_seed_load = 1'b1;
    @(posedge HCLK);
    #1;
    cfg_seed_load = 1'b0;
    m_lfsr = (s == 32'd0) ? SEED_C : s;
  endtask

  task automatic start_page(input int prob, input int budget, input bit en);
    cfg_prob       = 9'(prob);
    cfg_num_faults = 7'(budget);
    cfg_en         = en;
    model_build(prob, budget, en);
    page_start = 1'b1;
    @(posedge HCLK);
    #1;
    page_start = 1'b0;
  endtask

  task automatic drive(input int from, input int to, input int seedload_at);
    int guard;
    bit acc;
    for (int k = from; k < to; k++) begin
      in_valid = 1'b1;
      in_data  = stim[k];
      if (k == seedload_at) begin
        cfg_seed      = $urandom;
        cfg_seed_load = 1'b1;
      end
      guard = 0;
      acc   = 0;
      while (!acc && guard < 300) begin
        @(negedge HCLK);
        acc = in_ready;
        @(posedge HCLK);
        #1;
        guard++;
      end
      cfg_seed_load = 1'b0;
      if (!acc) begin
        timeout_fail("input_accept");
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_page();
    int guard;
    bit done;
    guard = 0;
    done  = 0;
    while (!done && guard < 300) begin
      @(negedge HCLK);
      done = page_done;
      @(posedge HCLK);
      #1;
      guard++;
    end
    if (!done) timeout_fail("page_done_wait");
    check("idle_after_page", busy, 1'b0);
    check("page_fault_total", fault_cnt, exp_total);
    m_lfsr = traj[PAGE];
  endtask

  function automatic int count_diff();
    int n;
    n = 0;
    for (int k = 0; k < PAGE; k++) if (cap_data[k] != stim[k]) n++;
    return n;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] lit5 [5];
    int mism;
    int fc_prev;
    int ok1;
    lit5 = '{8'h01, 8'h00, 8'h03, 8'h02, 8'h05};

    // reset state
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_page_done", page_done, 1'b0);
    check("rst_fault_cnt", fault_cnt, 7'd0);
    check("rst_out_last", out_last, 1'b0);
    HRESET = 1'b0;
    m_lfsr = SEED_C;
    mon_en = 1;
    @(posedge HCLK);
    #1;

    // prob 0: pure pass-through
    gen_stim(0);
    start_page(0, 80, 1);
    check("p0_busy", busy, 1'b1);
    drive(0, PAGE, -1);
    finish_page();
    check("p0_fault_cnt", fault_cnt, 7'd0);
    check("p0_diff_bytes", count_diff(), 0);

    // prob 256, budget 5, seed 1: first five bytes flip bit 0
    load_seed(32'd1);
    start_page(256, 5, 1);
    drive(0, PAGE, -1);
    finish_page();
    for (int k = 0; k < 5; k++) check("seed1_byte", cap_data[k], lit5[k]);
    check("seed1_byte5", cap_data[5], 8'h05);
    check("seed1_fault_cnt", fault_cnt, 7'd5);
    check("seed1_diff_bytes", count_diff(), 5);
    ok1 = 0;
    for (int k = 0; k < 5; k++) if ($countones(cap_data[k] ^ stim[k]) == 1) ok1++;
    check("seed1_single_bit", ok1, 5);

    // repeatability: same seed twice, prob 128
    gen_stim(1);
    load_seed(32'h1234_5678);
    start_page(128, 80, 1);
    drive(0, PAGE, -1);
    finish_page();
    for (int k = 0; k < PAGE; k++) cap_prev[k] = cap_data[k];
    fc_prev = int'(fault_cnt);
    check("rep_fault_cnt", fault_cnt, 7'd80);
    load_seed(32'h1234_5678);
    start_page(128, 80, 1);
    drive(0, PAGE, -1);
    finish_page();
    mism = 0;
    for (int k = 0; k < PAGE; k++) if (cap_data[k] != cap_prev[k]) mism++;
    check("rep_stream_mismatches", mism, 0);
    check("rep_fault_cnt_same", fault_cnt, fc_prev);

    // 30% out_ready with a seed load attempted mid-stream (must be ignored)
    ready_pct = 30;
    gen_stim(1);
    start_page(128, 80, 1);
    drive(0, PAGE, 500);
    finish_page();
    ready_pct = 100;
    // continuing without reseed proves exactly PAGE LFSR steps were taken
    gen_stim(0);
    start_page(256, 3, 1);
    drive(0, PAGE, -1);
    finish_page();
    check("cont_fault_cnt", fault_cnt, 7'd3);

    // abort at byte 1000 and restart
    load_seed(32'hCAFE_0001);
    gen_stim(0);
    start_page(200, 80, 1);
    drive(0, 1000, -1);
    begin
      int g;
      g = 0;
      while (out_valid && g < 50) begin
        @(posedge HCLK);
        #1;
        g++;
      end
      if (out_valid) timeout_fail("abort_drain");
    end
    m_lfsr = traj[1000];
    start_page(200, 80, 1);
    check("abort_fault_cnt", fault_cnt, 7'd0);
    check("abort_busy", busy, 1'b1);
    drive(0, PAGE, -1);
    finish_page();

    // budget above MAX_FAULTS clamps to 80
    start_page(256, 127, 1);
    drive(0, PAGE, -1);
    finish_page();
    check("clamp_fault_cnt", fault_cnt, 7'd80);
    check("clamp_diff_bytes", count_diff(), 80);

    // cfg_en = 0 with prob 256
    start_page(256, 80, 0);
    drive(0, PAGE, -1);
    finish_page();
    check("dis_fault_cnt", fault_cnt, 7'd0);
    check("dis_diff_bytes", count_diff(), 0);

    // seed 0 selects SEED: bit lfsr[10:8] of 0xACE12020 is 0
    load_seed(32'd0);
    start_page(256, 1, 1);
    drive(0, PAGE, -1);
    finish_page();
    check("seed0_byte0", cap_data[0], 8'h01);
    check("seed0_byte1", cap_data[1], 8'h01);

    // reset in the middle of a page
    start_page(64, 80, 1);
    drive(0, 300, -1);
    mon_en = 0;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_fault_cnt", fault_cnt, 7'd0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    HRESET = 1'b0;
    m_lfsr = SEED_C;
    @(posedge HCLK);
    #1;
    mon_en = 1;
    start_page(256, 2, 1);
    drive(0, PAGE, -1);
    finish_page();
    check("post_rst_byte0", cap_data[0], 8'h01);
    check("post_rst_byte1", cap_data[1], 8'h00);
    check("post_rst_byte2", cap_data[2], 8'h02);
    check("post_rst_fault_cnt", fault_cnt, 7'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
